// File: rtl/pll_reconfig_pkg.sv
// Shared constants, types and helpers for the PLL reconfiguration controller.
// Holds the management register map, the fixed M/N/C0 words, the per-profile
// K words, the FSM state encoding and the write-slot decode helpers.
package pll_reconfig_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 3;

  // Reconfig management register addresses
  localparam logic [ADDR_W-1:0] ADDR_MODE  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_N     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_M     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_C0    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_K     = ADDR_W'(7);

  // Register words; mode 0 selects waitrequest mode, N bypassed
  localparam logic [DATA_W-1:0] MODE_WORD  = 32'h0000_0000;
  localparam logic [DATA_W-1:0] M_WORD     = 32'h0000_0404;
  localparam logic [DATA_W-1:0] N_WORD     = 32'h0001_0000;
  localparam logic [DATA_W-1:0] C0_WORD    = 32'h0000_0404;
  localparam logic [DATA_W-1:0] START_WORD = 32'h0000_0000;
  localparam logic [DATA_W-1:0] K_NTSC     = 32'd2537930535;  // 53.693175 MHz
  localparam logic [DATA_W-1:0] K_PAL      = 32'd2201376898;  // 53.203425 MHz

  // Write slot indices, in issue order
  localparam logic [IDX_W-1:0] IDX_MODE  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_M     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_N     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_C0    = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_K     = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'(5);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mgmt_wr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_M,
    ST_WR_N,
    ST_WR_C0,
    ST_WR_K,
    ST_WR_START,
    ST_SETTLE,
    ST_WAIT_LOCK
  } state_e;

  function automatic logic is_wr_state(state_e s);
    return s inside {ST_WR_MODE, ST_WR_M, ST_WR_N, ST_WR_C0, ST_WR_K, ST_WR_START};
  endfunction

  function automatic logic [IDX_W-1:0] wr_index(state_e s);
    case (s)
      ST_WR_M:     return IDX_M;
      ST_WR_N:     return IDX_N;
      ST_WR_C0:    return IDX_C0;
      ST_WR_K:     return IDX_K;
      ST_WR_START: return IDX_START;
      default:     return IDX_MODE;
    endcase
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// PLL reconfig management bus (write-only use, waitrequest flow control).
//   master: drives mgmt_address/mgmt_write/mgmt_writedata/mgmt_read
//   slave : drives mgmt_waitrequest
interface pll_reconfig_ctrl_if;
  import pll_reconfig_pkg::*;

  logic [ADDR_W-1:0] mgmt_address;
  logic              mgmt_write;
  logic [DATA_W-1:0] mgmt_writedata;
  logic              mgmt_read;
  logic              mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_profile_rom.sv
// Write table for the reconfig sequence: (profile, slot) -> address/data.
//   sel  : 0 = NTSC, 1 = PAL (only the K word differs)
//   idx  : write slot index
//   wr_c : combinational address/data for that slot
module pll_profile_rom
  import pll_reconfig_pkg::*;
(
  input  logic             sel,
  input  logic [IDX_W-1:0] idx,
  output mgmt_wr_t         wr_c
);

  always_comb begin
    wr_c = '{addr: ADDR_MODE, data: MODE_WORD};
    case (idx)
      IDX_M:     wr_c = '{addr: ADDR_M,     data: M_WORD};
      IDX_N:     wr_c = '{addr: ADDR_N,     data: N_WORD};
      IDX_C0:    wr_c = '{addr: ADDR_C0,    data: C0_WORD};
      IDX_K:     wr_c = '{addr: ADDR_K,     data: sel ? K_PAL : K_NTSC};
      IDX_START: wr_c = '{addr: ADDR_START, data: START_WORD};
      default:   wr_c = '{addr: ADDR_MODE,  data: MODE_WORD};
    endcase
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: on cfg_req writes the mode/M/N/C0/K/start
// registers over the management bus, ignores lock for a settle window, then
// waits for lock (done pulse) or times out (sticky error).
//   clk, rst_n         : clock, async active-low reset
//   cfg_req, cfg_sel   : request pulse and profile select (0 NTSC, 1 PAL)
//   busy, done, error  : status (registered)
//   mgmt               : management bus master
//   pll_locked         : PLL lock, asynchronous to clk
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_req,
  input  logic                cfg_sel,
  output logic                busy,
  output logic                done,
  output logic                error,
  pll_reconfig_ctrl_if.master mgmt,
  input  logic                pll_locked
);

  localparam int unsigned LOCK_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [LOCK_W-1:0]   LOCK_MAX    = LOCK_W'(LOCK_TIMEOUT);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                fin_q, fin_d;
  logic [1:0]          sync_q, sync_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                mgmt_write_q, mgmt_write_d;
  logic [ADDR_W-1:0]   mgmt_address_q, mgmt_address_d;
  logic [DATA_W-1:0]   mgmt_writedata_q, mgmt_writedata_d;

  logic              wr_ack_c;
  logic              lock_s_c;
  logic              timeout_c;
  logic [LOCK_W-1:0] lock_inc_c;
  logic [IDX_W-1:0]  rom_idx_c;
  mgmt_wr_t          rom_wr_c;

  assign sync_d     = {sync_q[0], pll_locked};
  assign lock_s_c   = sync_q[1];
  assign wr_ack_c   = mgmt_write_q && !mgmt.mgmt_waitrequest;
  // Counter reaches LOCK_TIMEOUT on this edge; saturates, never wraps
  assign timeout_c  = (lock_cnt_q >= LOCK_LAST);
  assign lock_inc_c = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);

  // Next state; fin_q blocks a request landing in the done/error cycle
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    error_d      = error_q;
    done_d       = 1'b0;
    fin_d        = 1'b0;
    settle_cnt_d = settle_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_req && !fin_q) begin
          state_d = ST_WR_MODE;
          sel_d   = cfg_sel;
          error_d = 1'b0;
        end
      end
      ST_WR_MODE: if (wr_ack_c) state_d = ST_WR_M;
      ST_WR_M:    if (wr_ack_c) state_d = ST_WR_N;
      ST_WR_N:    if (wr_ack_c) state_d = ST_WR_C0;
      ST_WR_C0:   if (wr_ack_c) state_d = ST_WR_K;
      ST_WR_K:    if (wr_ack_c) state_d = ST_WR_START;
      ST_WR_START: begin
        if (wr_ack_c) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
          lock_cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        lock_cnt_d   = lock_inc_c;
        if (timeout_c) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          fin_d   = 1'b1;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        lock_cnt_d = lock_inc_c;
        if (lock_s_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          fin_d   = 1'b1;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          fin_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign rom_idx_c = wr_index(state_d);

  pll_profile_rom u_rom (
    .sel  (sel_d),
    .idx  (rom_idx_c),
    .wr_c (rom_wr_c)
  );

  // Bus outputs for the state being entered; a stall keeps state and so holds them
  always_comb begin
    mgmt_write_d     = is_wr_state(state_d);
    mgmt_address_d   = '0;
    mgmt_writedata_d = '0;
    if (mgmt_write_d) begin
      mgmt_address_d   = rom_wr_c.addr;
      mgmt_writedata_d = rom_wr_c.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      sel_q            <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      fin_q            <= 1'b0;
      sync_q           <= '0;
      settle_cnt_q     <= '0;
      lock_cnt_q       <= '0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= '0;
      mgmt_writedata_q <= '0;
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
      fin_q            <= fin_d;
      sync_q           <= sync_d;
      settle_cnt_q     <= settle_cnt_d;
      lock_cnt_q       <= lock_cnt_d;
      mgmt_write_q     <= mgmt_write_d;
      mgmt_address_q   <= mgmt_address_d;
      mgmt_writedata_q <= mgmt_writedata_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign mgmt.mgmt_write     = mgmt_write_q;
  assign mgmt.mgmt_address   = mgmt_address_q;
  assign mgmt.mgmt_writedata = mgmt_writedata_q;
  assign mgmt.mgmt_read      = 1'b0;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a waitrequest slave model that
// logs every completed write and flags any change of address/data mid-stall.
module tb_pll_reconfig_ctrl;

  logic clk        = 1'b0;
  logic rst_n      = 1'b1;
  logic cfg_req    = 1'b0;
  logic cfg_sel    = 1'b0;
  logic pll_locked = 1'b0;
  logic waitreq    = 1'b0;
  logic busy, done, error;

  pll_reconfig_ctrl_if mif();
  assign mif.mgmt_waitrequest = waitreq;

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(64), .SETTLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_sel    (cfg_sel),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .mgmt       (mif),
    .pll_locked (pll_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int          stall_n = 0;
  int          stall_ctr = 0;
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  logic [5:0] exp_addr [6] = '{6'd0, 6'd4, 6'd3, 6'd5, 6'd7, 6'd2};

  function automatic logic [31:0] exp_data(input int i, input logic pal);
    case (i)
      1:       return 32'h0000_0404;
      2:       return 32'h0001_0000;
      3:       return 32'h0000_0404;
      4:       return pal ? 32'd2201376898 : 32'd2537930535;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Slave: stall each write stall_n cycles, log completions, watch holds
  always @(negedge clk) begin
    if (!rst_n || !mif.mgmt_write) begin
      stall_ctr = 0;
      waitreq   = 1'b0;
    end else if (stall_ctr < stall_n) begin
      stall_ctr = stall_ctr + 1;
      waitreq   = 1'b1;
    end else begin
      stall_ctr = 0;
      waitreq   = 1'b0;
    end
    if (prev_stall && mif.mgmt_write &&
        (mif.mgmt_address !== prev_addr || mif.mgmt_writedata !== prev_data))
      hold_viol = hold_viol + 1;
    if (rst_n && mif.mgmt_write && !waitreq) begin
      log_addr.push_back(mif.mgmt_address);
      log_data.push_back(mif.mgmt_writedata);
      log_cyc.push_back(cyc);
    end
    prev_stall = rst_n && mif.mgmt_write && waitreq;
    prev_addr  = mif.mgmt_address;
    prev_data  = mif.mgmt_writedata;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    hold_viol = 0;
  endtask

  task automatic pulse_req(input logic sel);
    @(negedge clk);
    cfg_req = 1'b1;
    cfg_sel = sel;
    @(negedge clk);
    cfg_req = 1'b0;
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (log_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, mif.mgmt_write, mif.mgmt_read} !== 5'b0 ||
        mif.mgmt_address !== 6'd0 || mif.mgmt_writedata !== 32'd0) begin
      failures++;
      $display("FAIL reset_hold got busy=%b done=%b err=%b wr=%b rd=%b addr=%0d data=%0h exp all 0",
               busy, done, error, mif.mgmt_write, mif.mgmt_read, mif.mgmt_address, mif.mgmt_writedata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, mif.mgmt_write, mif.mgmt_read} !== 5'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b err=%b wr=%b rd=%b exp all 0",
               busy, done, error, mif.mgmt_write, mif.mgmt_read);
    end
  endtask

  // No stall, NTSC, lock raised 20 cycles after the start write
  task automatic test_basic();
    bit ok;
    int cs, at;
    clear_log();
    stall_n = 0;
    pll_locked = 1'b0;
    pulse_req(1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_rise got=%b exp=1", busy);
    end
    wait_writes(6, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_writes got=%0d writes exp=6", log_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data(i, 1'b0)) begin
          failures++;
          $display("FAIL basic_wr%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                   i, log_addr[i], log_data[i], exp_addr[i], exp_data(i, 1'b0));
        end
      end
      checks++;
      if (log_cyc[5] - log_cyc[0] !== 5) begin
        failures++;
        $display("FAIL basic_consecutive got span=%0d exp=5", log_cyc[5] - log_cyc[0]);
      end
      cs = log_cyc[5];
      while (cyc < cs + 20) @(negedge clk);
      pll_locked = 1'b1;
      wait_done(60, at);
      checks++;
      if (at !== cs + 23) begin
        failures++;
        $display("FAIL basic_done_time got=%0d exp=%0d", at, cs + 23);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy_fall got=%b exp=0", busy);
      end
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL basic_req_on_done got done=%b busy=%b exp 0 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || log_addr.size() !== 6) begin
        failures++;
        $display("FAIL basic_no_restart got busy=%b writes=%0d exp 0 6", busy, log_addr.size());
      end
    end
  endtask

  // 3-cycle stall per write with lock already high (stale lock)
  task automatic test_stall_stale();
    bit ok;
    int at;
    stall_n = 3;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();
    pulse_req(1'b0);
    wait_writes(6, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_writes got=%0d writes exp=6", log_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data(i, 1'b0) ||
            (i > 0 && log_cyc[i] - log_cyc[i-1] !== 4)) begin
          failures++;
          $display("FAIL stall_wr%0d got addr=%0d data=%0d exp addr=%0d data=%0d spacing 4",
                   i, log_addr[i], log_data[i], exp_addr[i], exp_data(i, 1'b0));
        end
      end
      checks++;
      if (hold_viol !== 0) begin
        failures++;
        $display("FAIL stall_hold got=%0d changes exp=0", hold_viol);
      end
      wait_done(60, at);
      checks++;
      if (at !== log_cyc[5] + 18) begin
        failures++;
        $display("FAIL stale_lock_done_time got=%0d exp=%0d", at, log_cyc[5] + 18);
      end
    end
    stall_n = 0;
  endtask

  // PAL profile; a request mid-sequence must not start a second run
  task automatic test_pal_midreq();
    bit ok;
    int at;
    stall_n = 1;
    pll_locked = 1'b1;
    clear_log();
    pulse_req(1'b1);
    wait_writes(2, ok);
    pulse_req(1'b0);
    wait_done(200, at);
    checks++;
    if (at < 0 || log_addr.size() !== 6) begin
      failures++;
      $display("FAIL pal_run got done_at=%0d writes=%0d exp done and 6", at, log_addr.size());
    end else begin
      checks++;
      if (log_addr[4] !== 6'd7 || log_data[4] !== 32'd2201376898) begin
        failures++;
        $display("FAIL pal_k got addr=%0d data=%0d exp addr=7 data=2201376898",
                 log_addr[4], log_data[4]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || log_addr.size() !== 6) begin
      failures++;
      $display("FAIL pal_no_second got busy=%b writes=%0d exp 0 6", busy, log_addr.size());
    end
    stall_n = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    int cs, at;
    bit done_seen;
    stall_n = 0;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    clear_log();
    pulse_req(1'b0);
    wait_writes(6, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_writes got=%0d writes exp=6", log_addr.size());
    end else begin
      cs = log_cyc[5];
      at = -1;
      done_seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
        @(negedge clk);
        if (done === 1'b1) done_seen = 1'b1;
        if (error === 1'b1) begin
          at = cyc;
          break;
        end
      end
      checks++;
      if (at !== cs + 65) begin
        failures++;
        $display("FAIL timeout_time got=%0d exp=%0d", at, cs + 65);
      end
      checks++;
      if (done_seen || busy !== 1'b0) begin
        failures++;
        $display("FAIL timeout_status got done_seen=%b busy=%b exp 0 0", done_seen, busy);
      end
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
      checks++;
      if (busy !== 1'b0 || error !== 1'b1) begin
        failures++;
        $display("FAIL timeout_req_on_error got busy=%b err=%b exp 0 1", busy, error);
      end
      pulse_req(1'b0);
      checks++;
      if (busy !== 1'b1 || error !== 1'b0) begin
        failures++;
        $display("FAIL timeout_clear got busy=%b err=%b exp 1 0", busy, error);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Async reset during the C0 stall, then a clean restart
  task automatic test_reset_mid();
    bit ok;
    int at;
    stall_n = 3;
    pll_locked = 1'b0;
    clear_log();
    pulse_req(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mif.mgmt_write === 1'b1 && mif.mgmt_address === 6'd5 && waitreq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_reach_c0 got addr=%0d exp 5 stalled", mif.mgmt_address);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mif.mgmt_write !== 1'b0 || busy !== 1'b0 || mif.mgmt_address !== 6'd0) begin
      failures++;
      $display("FAIL rstmid_async got wr=%b busy=%b addr=%0d exp 0 0 0",
               mif.mgmt_write, busy, mif.mgmt_address);
    end
    checks++;
    if (log_addr.size() !== 3) begin
      failures++;
      $display("FAIL rstmid_partial got=%0d writes exp=3", log_addr.size());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall_n = 0;
    pll_locked = 1'b1;
    clear_log();
    pulse_req(1'b0);
    wait_writes(6, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_restart got=%0d writes exp=6", log_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data(i, 1'b0)) begin
          failures++;
          $display("FAIL rstmid_wr%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                   i, log_addr[i], log_data[i], exp_addr[i], exp_data(i, 1'b0));
        end
      end
      wait_done(60, at);
      checks++;
      if (at < 0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_done got done_at=%0d busy=%b exp done and 0", at, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_stale();
    test_pal_midreq();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
